// File: rtl/spi_slave_pkg.sv
// Shared constants and types for the SPI slave block.
// Word width, bit-counter width and synchronizer depth live here so the
// top level and the synchronizer agree on them.
package spi_slave_pkg;

  localparam int WORD_W      = 16;
  localparam int CNT_W       = 5;
  localparam int SYNC_STAGES = 2;

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [CNT_W-1:0]  count_t;

  // Bit count that marks a complete word.
  localparam count_t FULL_COUNT = count_t'(WORD_W);

  // Counts received bits and holds at a full word. Extra clocks in a long
  // frame therefore still leave the count at "complete".
  function automatic count_t sat_inc(input count_t c);
    return (c == FULL_COUNT) ? c : c + 1'b1;
  endfunction

endpackage

// File: rtl/spi_sync.sv
// Multi-flop synchronizer that brings an asynchronous SPI pin into the clk
// domain. The reset value is a parameter so that idle-high lines such as the
// slave select come out of reset looking inactive.
module spi_sync
  import spi_slave_pkg::*;
#(
  parameter int   STAGES    = SYNC_STAGES,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic sync_out
);

  logic [STAGES-1:0] stages;

  // Shift the pin through the flop chain; the last stage is the clean copy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stages <= {STAGES{RESET_VAL}};
    end else begin
      stages <= {stages[STAGES-2:0], async_in};
    end
  end

  assign sync_out = stages[STAGES-1];

endmodule

// File: rtl/spi_slave.sv
// SPI mode-0 slave. It receives a 16-bit command on MOSI and returns a
// 16-bit response on MISO, both MSB first. All SPI pins are oversampled on clk.
// Optional build macro SPI_SLAVE_TRISTATE_EN: when it is defined, MISO is
// high-impedance while the slave is deselected. When it is not defined,
// MISO drives 0 while the slave is deselected.
module spi_slave
  import spi_slave_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              SS_n,
  input  logic              SCLK,
  input  logic              MOSI,
  output logic              MISO,
  input  logic [WORD_W-1:0] tx_data,
  output logic [WORD_W-1:0] cmd_rcvd,
  output logic              cmd_rdy,
  output logic              rsp_rdy
);

  logic   ss_sync;
  logic   sclk_sync;
  logic   mosi_sync;
  logic   ss_prev;
  logic   sclk_prev;
  logic   ss_fall;
  logic   ss_rise;
  logic   sclk_rise;
  logic   sclk_fall;
  logic   selected;
  word_t  rx_shift;
  word_t  tx_shift;
  count_t bit_cnt;

  spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ss (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (SS_n),
    .sync_out (ss_sync)
  );

  spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (SCLK),
    .sync_out (sclk_sync)
  );

  spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (MOSI),
    .sync_out (mosi_sync)
  );

  // Delay the synchronized select and clock by one more flop. Comparing this
  // delayed copy with the current value gives the edge strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ss_prev   <= 1'b1;
      sclk_prev <= 1'b0;
    end else begin
      ss_prev   <= ss_sync;
      sclk_prev <= sclk_sync;
    end
  end

  assign ss_fall   =  ss_prev   & ~ss_sync;
  assign ss_rise   = ~ss_prev   &  ss_sync;
  assign sclk_rise = ~sclk_prev &  sclk_sync;
  assign sclk_fall =  sclk_prev & ~sclk_sync;
  assign selected  = ~ss_sync;

  // Receive path. Shift MOSI in on each SCLK rise while selected, and count
  // the bits. A new frame restarts the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_shift <= '0;
      bit_cnt  <= '0;
    end else if (ss_fall) begin
      bit_cnt  <= '0;
    end else if (selected && sclk_rise) begin
      rx_shift <= {rx_shift[WORD_W-2:0], mosi_sync};
      bit_cnt  <= sat_inc(bit_cnt);
    end
  end

  // Transmit path. Capture the response word when the frame opens. Advance
  // to the next bit on each SCLK fall, so the master samples a stable bit on
  // the following rise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_shift <= '0;
    end else if (ss_fall) begin
      tx_shift <= tx_data;
    end else if (selected && sclk_fall) begin
      tx_shift <= {tx_shift[WORD_W-2:0], 1'b0};
    end
  end

  // Handshake outputs. rsp_rdy marks the capture of tx_data. cmd_rdy is
  // cleared when a frame opens, and is set when a frame closes with a full
  // word. A frame that closes early leaves the previous command untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_rcvd <= '0;
      cmd_rdy  <= 1'b0;
      rsp_rdy  <= 1'b0;
    end else begin
      rsp_rdy <= ss_fall;
      if (ss_fall) begin
        cmd_rdy <= 1'b0;
      end else if (ss_rise && (bit_cnt == FULL_COUNT)) begin
        cmd_rcvd <= rx_shift;
        cmd_rdy  <= 1'b1;
      end
    end
  end

`ifdef SPI_SLAVE_TRISTATE_EN
  assign MISO = ss_sync ? 1'bz : tx_shift[WORD_W-1];
`else
  assign MISO = ss_sync ? 1'b0 : tx_shift[WORD_W-1];
`endif

endmodule

// File: tb/tb_spi_slave.sv
// Self-checking bench for spi_slave. A master model drives mode-0 frames at
// clk/16. The bench keeps an expected command and ready flag that update
// when each frame closes. One monitor compares the DUT against them on
// every settled clock.
`timescale 1ns/100ps
module tb_spi_slave;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        SS_n = 1'b1;
  logic        SCLK = 1'b0;
  logic        MOSI = 1'b0;
  logic [15:0] tx_data = 16'h0000;
  wire         MISO;
  logic [15:0] cmd_rcvd;
  logic        cmd_rdy;
  logic        rsp_rdy;

  int          checks = 0;
  int          failures = 0;
  logic [15:0] exp_cmd = 16'h0000;
  logic        exp_rdy = 1'b0;
  logic [31:0] master_rx = 32'h0;

`ifdef SPI_SLAVE_TRISTATE_EN
  localparam logic IDLE_MISO = 1'bz;
`else
  localparam logic IDLE_MISO = 1'b0;
`endif

  spi_slave dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .SS_n     (SS_n),
    .SCLK     (SCLK),
    .MOSI     (MOSI),
    .MISO     (MISO),
    .tx_data  (tx_data),
    .cmd_rcvd (cmd_rcvd),
    .cmd_rdy  (cmd_rdy),
    .rsp_rdy  (rsp_rdy)
  );

  always #12.5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One master frame. It sends nbits of word MSB first and offers rsp_word
  // as the response. If rst_at is not negative, rst_n is pulsed just before
  // that bit.
  task automatic applyStimulus(input logic [31:0] word, input int nbits,
                               input int rst_at, input logic [15:0] rsp_word);
    logic [31:0] rx;
    logic [31:0] rx_exp;
    int          pulses;
    bit          aborted;
    rx      = 32'h0;
    aborted = 1'b0;
    pulses  = 0;
    tx_data = rsp_word;
    tick(1);
    SS_n    = 1'b0;
    exp_rdy = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (rsp_rdy) pulses++;
    end
    checkOutput("rsp_rdy_single_pulse", pulses, 1);
    checkOutput("cmd_rdy_clear_on_open", {31'b0, cmd_rdy}, 32'd0);
    tick(1);
    for (int i = 0; i < nbits; i++) begin
      if (i == rst_at) begin
        rst_n   = 1'b0;
        exp_cmd = 16'h0000;
        exp_rdy = 1'b0;
        aborted = 1'b1;
        tick(3);
        rst_n = 1'b1;
        tick(2);
      end
      MOSI = word[nbits-1-i];
      tick(8);
      rx   = {rx[30:0], MISO};
      SCLK = 1'b1;
      tick(8);
      SCLK = 1'b0;
    end
    tick(8);
    SS_n = 1'b1;
    if (nbits >= 16 && !aborted) begin
      exp_cmd = word[15:0];
      exp_rdy = 1'b1;
    end
    tick(8);
    master_rx = rx;
    if (!aborted) begin
      rx_exp = (nbits >= 16) ? (32'(rsp_word) << (nbits - 16))
                             : (32'(rsp_word) >> (16 - nbits));
      checkOutput("master_rx", rx, rx_exp);
    end
  endtask

  // Monitor: compare the DUT against the expected state on every clock
  // once the synchronizer has settled after a select edge.
  initial begin
    logic prev_ss;
    int   settle;
    prev_ss = 1'b1;
    settle  = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        checkOutput("reset_cmd_rcvd", 32'(cmd_rcvd), 32'h0);
        checkOutput("reset_cmd_rdy", {31'b0, cmd_rdy}, 32'h0);
        checkOutput("reset_rsp_rdy", {31'b0, rsp_rdy}, 32'h0);
        checkOutput("reset_miso", {31'b0, MISO}, {31'b0, IDLE_MISO});
      end else begin
        if (SS_n !== prev_ss) settle = 4;
        else if (settle > 0) settle--;
        if (settle == 0) begin
          checkOutput("mon_cmd_rcvd", 32'(cmd_rcvd), 32'(exp_cmd));
          checkOutput("mon_cmd_rdy", {31'b0, cmd_rdy}, {31'b0, exp_rdy});
          if (SS_n) checkOutput("mon_idle_miso", {31'b0, MISO}, {31'b0, IDLE_MISO});
        end
      end
      prev_ss = SS_n;
    end
  end

  // Watchdog so that the run always ends.
  initial begin
    #2ms;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed scenarios with hand-computed expectations.
  initial begin
    tick(4);
    checkOutput("lit_reset_cmd_rcvd", 32'(cmd_rcvd), 32'h0000);
    checkOutput("lit_reset_cmd_rdy", {31'b0, cmd_rdy}, 32'd0);
    checkOutput("lit_reset_miso", {31'b0, MISO}, {31'b0, IDLE_MISO});
    rst_n = 1'b1;
    tick(4);

    applyStimulus(32'h0000A5C3, 16, -1, 16'h0001);
    checkOutput("lit_frame_cmd", 32'(cmd_rcvd), 32'h0000A5C3);
    checkOutput("lit_frame_rdy", {31'b0, cmd_rdy}, 32'd1);
    checkOutput("lit_frame_master_rx", master_rx, 32'h00000001);

    applyStimulus(32'h000002EF, 16, -1, 16'hBEEF);
    checkOutput("lit_b2b_first_cmd", 32'(cmd_rcvd), 32'h000002EF);
    applyStimulus(32'h00001234, 16, -1, 16'h8001);
    checkOutput("lit_b2b_second_cmd", 32'(cmd_rcvd), 32'h00001234);
    checkOutput("lit_b2b_second_rdy", {31'b0, cmd_rdy}, 32'd1);
    checkOutput("lit_b2b_master_rx", master_rx, 32'h00008001);

    applyStimulus(32'h0000A5C3, 16, -1, 16'h0F0F);
    applyStimulus(32'h000000FF, 8, -1, 16'hC0DE);
    checkOutput("lit_short_cmd", 32'(cmd_rcvd), 32'h0000A5C3);
    checkOutput("lit_short_rdy", {31'b0, cmd_rdy}, 32'd0);

    applyStimulus(32'h000ABCDE, 20, -1, 16'h7E57);
    checkOutput("lit_long_cmd", 32'(cmd_rcvd), 32'h0000BCDE);
    checkOutput("lit_long_rdy", {31'b0, cmd_rdy}, 32'd1);

    applyStimulus(32'h0000FFFF, 16, 7, 16'h1111);
    checkOutput("lit_abort_cmd", 32'(cmd_rcvd), 32'h0000);
    checkOutput("lit_abort_rdy", {31'b0, cmd_rdy}, 32'd0);
    applyStimulus(32'h00005A5A, 16, -1, 16'hA5A5);
    checkOutput("lit_after_abort_cmd", 32'(cmd_rcvd), 32'h00005A5A);
    checkOutput("lit_after_abort_rdy", {31'b0, cmd_rdy}, 32'd1);

    for (int i = 0; i < 6; i++) begin
      MOSI = ~MOSI;
      SCLK = 1'b1;
      tick(8);
      SCLK = 1'b0;
      tick(8);
    end
    checkOutput("lit_idle_cmd", 32'(cmd_rcvd), 32'h00005A5A);
    checkOutput("lit_idle_rdy", {31'b0, cmd_rdy}, 32'd1);
    checkOutput("lit_idle_miso", {31'b0, MISO}, {31'b0, IDLE_MISO});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spi_slave.md
SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 SHALL have port clk, input, 1 bit: system clock (40 MHz nominal).
REQ-002 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-003 SHALL have port SS_n, input, 1 bit: active-low slave select from master.
REQ-004 SHALL have port SCLK, input, 1 bit: SPI clock, clk/16, idles low (mode 0).
REQ-005 SHALL have port MOSI, input, 1 bit: serial data from master, MSB first.
REQ-006 SHALL have port MISO, output, 1 bit: serial response to master, MSB first.
REQ-007 SHALL have port tx_data, input, 16 bits: response word sent during the next transaction.
REQ-008 SHALL have port cmd_rcvd, output, 16 bits: last complete word received.
REQ-009 SHALL have port cmd_rdy, output, 1 bit: level, high while cmd_rcvd holds a new complete word.
REQ-010 SHALL have port rsp_rdy, output, 1 bit: one-clk pulse when tx_data is captured for transmission.

Function
REQ-011 SHALL pass SS_n, SCLK and MOSI each through a 2-flop synchronizer on clk; edges are detected by comparing synchronized stage 2 with a third flop.
REQ-012 On detected SS_n fall: load tx_data into 16-bit tx shift register, clear bit counter, clear cmd_rdy, pulse rsp_rdy for exactly one clk.
REQ-013 MISO SHALL equal tx shift register bit 15 while SS_n (synchronized) is low.
REQ-014 On detected SCLK rise with SS_n low: shift synchronized MOSI into LSB of 16-bit rx shift register (shift left) and increment bit counter, saturating at 16.
REQ-015 On detected SCLK fall with SS_n low: shift tx register left by one, filling 0.
REQ-016 On detected SS_n rise: if bit counter == 16, copy rx register to cmd_rcvd and set cmd_rdy in the same clk; otherwise discard, leaving cmd_rcvd and cmd_rdy unchanged.
REQ-017 More than 16 rising edges in one frame: rx register keeps last 16 bits; cmd_rdy still asserted at SS_n rise.
REQ-018 SCLK edges while SS_n high SHALL be ignored.
REQ-019 cmd_rdy latency: high no later than 4 clk after the SS_n rising edge at the port.
REQ-020 SS_n fall and SS_n rise in consecutive frames: cmd_rdy from frame N stays high until frame N+1 SS_n fall.

Reset
REQ-021 On rst_n low: cmd_rcvd=0, cmd_rdy=0, rsp_rdy=0, rx/tx shift registers=0, bit counter=0, SS_n sync flops=1, SCLK/MOSI sync flops=0.
REQ-022 Reset asserted mid-frame SHALL abort the frame; no cmd_rdy for that frame even after SS_n rises.

Configuration
REQ-023 Macro SPI_SLAVE_TRISTATE_EN defined: MISO SHALL be high-impedance while synchronized SS_n is high.
REQ-024 SPI_SLAVE_TRISTATE_EN undefined: MISO SHALL drive 0 while synchronized SS_n is high.

Structure
REQ-025 Shared package spi_slave_pkg SHALL hold WORD_W=16, CNT_W=5, SYNC_STAGES=2.
REQ-026 One sub-module spi_sync (parameterized 2-flop synchronizer, reset value parameter) SHALL be instantiated for SS_n, SCLK, MOSI.

Verification
REQ-027 Reset: rst_n low -> cmd_rcvd=0x0000, cmd_rdy=0, rsp_rdy=0, MISO 0 or Z per macro.
REQ-028 tx_data=0x0001, master sends 0xA5C3 -> rsp_rdy one-clk pulse after SS_n fall, cmd_rcvd=0xA5C3 and cmd_rdy=1 within 4 clk of SS_n rise, master receives 0x0001.
REQ-029 Back-to-back frames 0x02EF then 0x1234 -> cmd_rdy drops at second SS_n fall, cmd_rcvd=0x1234 after second frame.
REQ-030 Short frame, 8 SCLK pulses of 0xFF after a 0xA5C3 frame -> cmd_rcvd remains 0xA5C3, cmd_rdy not re-asserted.
REQ-031 rst_n pulsed after 7 bits of a frame -> outputs reset, no cmd_rdy; following full frame 0x5A5A received correctly.
REQ-032 SS_n high with SCLK toggling -> cmd_rdy, cmd_rcvd unchanged; MISO=Z with SPI_SLAVE_TRISTATE_EN, 0 without.
